// File: rtl/bp2rast_pixel_decoder_if.sv
// Bus between the address generator / display RAM side and the pixel decoder.
// Carries the pixel-clock phase, per-pixel command byte, mode/bg/fg word,
// RAM read data, and the decoded colour index going on to the palette/mixer.
// There is no valid/ready handshake here: every field is qualified solely by
// the pixel-clock phase (a tick is any cycle with pc_ena_in == 0), and the
// decoder consumes or produces one pixel per tick unconditionally.
interface bp2rast_pixel_decoder_if;
    logic [3:0]  pc_ena_in;
    logic [7:0]  cmd_in;
    logic [23:0] bp_2_rast_cmd;
    logic [15:0] ram_din;
    logic [15:0] pixel_out;
    logic        window_out;
    logic [3:0]  pc_ena_out;

    modport master (
        output pc_ena_in,
        output cmd_in,
        output bp_2_rast_cmd,
        output ram_din,
        input  pixel_out,
        input  window_out,
        input  pc_ena_out
    );

    modport slave (
        input  pc_ena_in,
        input  cmd_in,
        input  bp_2_rast_cmd,
        input  ram_din,
        output pixel_out,
        output window_out,
        output pc_ena_out
    );
endinterface

// File: rtl/bp2rast_pixel_decoder.sv
// Pixel decoder at the end of the address-generator command stream.
// Delays each command byte by RAM_READ_CYCLES ticks so it meets the RAM data
// fetched for its address, then extracts the addressed pixel at 1/2/4/8 bpp
// and maps it to a colour index.
// Optional build macro: BP2R_TWO_BYTE_COLOUR_EN -- when defined, a command
// with bit 6 set passes the full 16-bit RAM word through as the pixel.
// RAM_READ_CYCLES must lie in 1..8.
module bp2rast_pixel_decoder #(
    parameter int RAM_READ_CYCLES = 3
) (
    input logic                     clk,
    input logic                     reset,
    bp2rast_pixel_decoder_if.slave  bus
);

    logic tick;
    assign tick = (bus.pc_ena_in == 4'd0);

    // Command delay line: window enable and sub-pixel X per stage.
    logic [RAM_READ_CYCLES-1:0]      en_q;
    logic [RAM_READ_CYCLES-1:0][2:0] sx_q;
    logic                            en_d;
    logic [2:0]                      sx_d;

    assign en_d = en_q[RAM_READ_CYCLES-1];
    assign sx_d = sx_q[RAM_READ_CYCLES-1];

    // Shift the command fields one stage per tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
            sx_q <= '0;
        end else if (tick) begin
            en_q[0] <= bus.cmd_in[7];
            sx_q[0] <= bus.cmd_in[2:0];
            for (int i = 1; i < RAM_READ_CYCLES; i++) begin
                en_q[i] <= en_q[i-1];
                sx_q[i] <= sx_q[i-1];
            end
        end
    end

`ifdef BP2R_TWO_BYTE_COLOUR_EN
    logic [RAM_READ_CYCLES-1:0] two_q;
    logic                       two_d;

    assign two_d = two_q[RAM_READ_CYCLES-1];

    // Shift the 2-byte colour request alongside the other command fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            two_q <= '0;
        end else if (tick) begin
            two_q[0] <= bus.cmd_in[6];
            for (int i = 1; i < RAM_READ_CYCLES; i++) begin
                two_q[i] <= two_q[i-1];
            end
        end
    end
`endif

    // Latched mode/bg/fg; only mode[1:0] matters for extraction.
    logic [1:0] mode_q;
    logic [7:0] fg_q;
    logic [7:0] bg_q;

    // Reload mode/colours only while the delayed window is closed, so a
    // change issued mid-window waits until the window ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 2'd0;
            fg_q   <= 8'h00;
            bg_q   <= 8'h00;
        end else if (tick && !en_d) begin
            mode_q <= bus.bp_2_rast_cmd[1:0];
            fg_q   <= bus.bp_2_rast_cmd[23:16];
            bg_q   <= bus.bp_2_rast_cmd[15:8];
        end
    end

    // Pixel extraction: shift the addressed pixel up to the MSB end.
    logic [7:0]  byte_lo;
    logic [7:0]  pair_sh;
    logic [7:0]  bit_sh;
    logic [7:0]  pix_lo;
    logic [15:0] pix_next;

    assign byte_lo = bus.ram_din[7:0];
    assign pair_sh = byte_lo << {sx_d[2:1], 1'b0};
    assign bit_sh  = byte_lo << sx_d;

    // Select the colour index for the pixel paired with this tick's RAM data.
    always_comb begin
        pix_lo = 8'h00;
        case (mode_q)
            2'd0:    pix_lo = byte_lo;
            2'd1:    pix_lo = {fg_q[7:4], (sx_d[2] ? byte_lo[3:0] : byte_lo[7:4])};
            2'd2:    pix_lo = {fg_q[7:2], pair_sh[7:6]};
            default: pix_lo = bit_sh[7] ? fg_q : bg_q;
        endcase
        pix_next = {8'h00, pix_lo};
`ifdef BP2R_TWO_BYTE_COLOUR_EN
        if (two_d) begin
            pix_next = bus.ram_din;
        end
`endif
        // Window closed: emit the bg being latched on this same tick.
        if (!en_d) begin
            pix_next = {8'h00, bus.bp_2_rast_cmd[15:8]};
        end
    end

    logic [15:0] pixel_q;
    logic        window_q;
    logic [3:0]  pc_ena_q;

    // Register pixel and window on ticks; they hold between ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_q  <= 16'h0000;
            window_q <= 1'b0;
        end else if (tick) begin
            pixel_q  <= pix_next;
            window_q <= en_d;
        end
    end

    // Phase counter follows one clk behind so it lines up with pixel updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_ena_q <= 4'd0;
        end else begin
            pc_ena_q <= bus.pc_ena_in;
        end
    end

    assign bus.pixel_out  = pixel_q;
    assign bus.window_out = window_q;
    assign bus.pc_ena_out = pc_ena_q;

    // Bits of the inputs this decoder never looks at.
    logic unused_bits;
    assign unused_bits = ^{bus.cmd_in[6:3], bus.ram_din[15:8], bus.bp_2_rast_cmd[7:2]};

endmodule

// File: tb/tb_bp2rast_pixel_decoder.sv
// Testbench for bp2rast_pixel_decoder (RAM_READ_CYCLES = 3).
// Expected {window, pixel} values are queued when a command is driven and
// popped on the tick its RAM data is presented.
module tb_bp2rast_pixel_decoder;
    localparam int RRC = 3;

    logic clk = 1'b0;
    logic reset;

    bp2rast_pixel_decoder_if bus ();

    bp2rast_pixel_decoder #(.RAM_READ_CYCLES(RRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [15:0] ram_q[$];
    logic [16:0] hold_exp;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one command against its RAM word and mode word.
    function automatic logic [16:0] model(input logic [7:0] cmd, input logic [15:0] ram,
                                          input logic [23:0] word);
        logic [7:0] fg;
        logic [7:0] bg;
        logic [7:0] p;
        logic [2:0] s;
        fg = word[23:16];
        bg = word[15:8];
        s  = cmd[2:0];
        if (!cmd[7]) return {1'b0, 8'h00, bg};
`ifdef BP2R_TWO_BYTE_COLOUR_EN
        if (cmd[6]) return {1'b1, ram};
`endif
        case (word[1:0])
            2'd0: p = ram[7:0];
            2'd1: p = s[2] ? {fg[7:4], ram[3:0]} : {fg[7:4], ram[7:4]};
            2'd2: begin
                case (s[2:1])
                    2'd0:    p = {fg[7:2], ram[7:6]};
                    2'd1:    p = {fg[7:2], ram[5:4]};
                    2'd2:    p = {fg[7:2], ram[3:2]};
                    default: p = {fg[7:2], ram[1:0]};
                endcase
            end
            default: p = ram[3'd7 - s] ? fg : bg;
        endcase
        return {1'b1, 8'h00, p};
    endfunction

    // One non-tick cycle with junk on every input; outputs must hold.
    task automatic idle_phase(input logic [3:0] ph);
        bus.pc_ena_in     = ph;
        bus.cmd_in        = 8'($urandom);
        bus.ram_din       = 16'($urandom);
        bus.bp_2_rast_cmd = 24'($urandom);
        @(posedge clk);
        #1;
        check("hold", {bus.window_out, bus.pixel_out}, hold_exp);
        check("pc_ena_out", {13'd0, bus.pc_ena_out}, {13'd0, ph});
    endtask

    // Three idle cycles then one tick carrying cmd; ram is queued for RRC ticks later.
    task automatic tick(input logic [7:0] cmd, input logic [15:0] ram,
                        input logic [23:0] drive_word, input logic [23:0] exp_word);
        for (int ph = 1; ph < 4; ph++) idle_phase(4'(ph));
        bus.pc_ena_in     = 4'd0;
        bus.cmd_in        = cmd;
        bus.bp_2_rast_cmd = drive_word;
        ram_q.push_back(ram);
        exp_q.push_back(model(cmd, ram, exp_word));
        if (ram_q.size() > RRC) bus.ram_din = ram_q.pop_front();
        else bus.ram_din = 16'($urandom);
        if (exp_q.size() > RRC) hold_exp = exp_q.pop_front();
        else hold_exp = {9'd0, drive_word[15:8]};
        @(posedge clk);
        #1;
        check("pixel", {bus.window_out, bus.pixel_out}, hold_exp);
        check("pc_ena_out_tick", {13'd0, bus.pc_ena_out}, 17'd0);
    endtask

    task automatic offs(input logic [23:0] word);
        for (int i = 0; i < 3; i++) tick({1'b0, 7'($urandom)}, 16'($urandom), word, word);
    endtask

    task automatic zero_check(input string tag);
        check(tag, {bus.window_out, bus.pixel_out}, 17'd0);
        check({tag, "_pc"}, {13'd0, bus.pc_ena_out}, 17'd0);
    endtask

    initial begin
        logic [23:0] w;
        logic [23:0] w8;

        reset             = 1'b1;
        bus.pc_ena_in     = 4'd2;
        bus.cmd_in        = 8'h00;
        bus.ram_din       = 16'h0000;
        bus.bp_2_rast_cmd = 24'h000000;
        hold_exp          = 17'd0;
        repeat (2) @(posedge clk);
        #1;
        zero_check("reset");
        reset = 1'b0;

        // 1bpp, fg=0F bg=01, ram A5, sub_x 0..7.
        w = {8'h0F, 8'h01, 8'h03};
        offs(w);
        for (int s = 0; s < 8; s++) tick({5'b10000, 3'(s)}, 16'h00A5, w, w);

        // 4bpp, fg=C0 bg=22, ram 3E: sub_x 0, 4, 5, 3.
        w = {8'hC0, 8'h22, 8'h01};
        offs(w);
        tick(8'h80, 16'h003E, w, w);
        tick(8'h84, 16'h003E, w, w);
        tick(8'h85, 16'h003E, w, w);
        tick(8'h83, 16'h003E, w, w);
        // Mode switched to 8bpp mid-window: still decoded as 4bpp.
        w8 = {8'hC0, 8'h22, 8'h00};
        for (int i = 0; i < 4; i++) tick({5'b10000, 3'($urandom)}, 16'($urandom), w8, w);

        // Window off shows bg 22, then 8bpp takes effect; C0 with 1234.
        offs(w8);
        tick(8'hC0, 16'h1234, w8, w8);
        for (int i = 0; i < 4; i++) tick({2'b11, 6'($urandom)}, 16'($urandom), w8, w8);

        // 2bpp, sub_x 0..7.
        w = {8'hA4, 8'h5A, 8'h02};
        offs(w);
        for (int s = 0; s < 8; s++) tick({5'b10000, 3'(s)}, 16'($urandom), w, w);

        // Random sections with random window bits.
        for (int k = 0; k < 3; k++) begin
            w = 24'($urandom);
            offs(w);
            for (int i = 0; i < 10; i++) tick(8'($urandom), 16'($urandom), w, w);
            for (int i = 0; i < 3; i++) tick({1'b1, 7'($urandom)}, 16'($urandom), w, w);
        end

        // Reset in the middle of an enabled line.
        #2;
        reset = 1'b1;
        #1;
        zero_check("reset_mid");
        @(posedge clk);
        #1;
        zero_check("reset_hold");
        reset = 1'b0;
        exp_q.delete();
        ram_q.delete();
        hold_exp = 17'd0;

        // Fresh commands: first RRC ticks give bg 77 only.
        w = {8'h3C, 8'h77, 8'h03};
        for (int i = 0; i < 6; i++) tick({1'b1, 7'($urandom)}, 16'($urandom), w, w);
        offs(w);
        offs(w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp2rast_pixel_decoder.md
Name: bp2rast_pixel_decoder

Overview:
Receiving end of the address-generator command stream. Takes the per-pixel command byte (window enable, 2-byte colour flag, sub-pixel X) and the mode/bg/fg word issued alongside each read address. Delays the command to line up with the RAM data returned for that address, then extracts the addressed pixel at 1/2/4/8 bits per pixel and emits a colour index. Sits between the read-address generator / display RAM and the palette / layer mixer.

Parameters:
RAM_READ_CYCLES, 3, pixel-enable ticks between a command being presented on cmd_in and its RAM data arriving on ram_din; legal range 1..8.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pc_ena_in  input  4  pixel-clock phase counter; a "tick" is any cycle where pc_ena_in == 0
cmd_in  input  8  [7] window enable, [6] 2-byte colour request, [5:3] ignored, [2:0] sub-pixel X bit offset
bp_2_rast_cmd  input  24  {fg_colour[23:16], bg_colour[15:8], mode[7:0]}; mode[1:0]: 0 = 8bpp, 1 = 4bpp, 2 = 2bpp, 3 = 1bpp
ram_din  input  16  [7:0] addressed byte, [15:8] addressed byte + 1
pixel_out  output  16  colour index/word for the current pixel
window_out  output  1  delayed window enable aligned with pixel_out
pc_ena_out  output  4  pc_ena_in delayed 1 clk, aligned with pixel_out updates

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. All state updates on posedge clk, and only on ticks, except pc_ena_out, which updates every clk.
- Reset values: pixel_out = 0, window_out = 0, pc_ena_out = 0, every command delay-line stage = 0 (window disabled), latched mode/bg/fg = 0.
- Command delay line: RAM_READ_CYCLES stages of cmd_in[7:6] and cmd_in[2:0], shifted one stage per tick. The output stage is paired with ram_din on the same tick.
- Mode latch: bp_2_rast_cmd is sampled on a tick only when the delayed window enable is 0. A mid-window change is deferred until the window closes.
- Pixel extraction on each tick, using the delayed sub_x and the latched mode. Pixels are packed MSB-first.
  - 8bpp: p = ram_din[7:0]; sub_x ignored.
  - 4bpp: sub_x[2] selects the nibble; 0 gives [7:4], 1 gives [3:0]. sub_x[1:0] masked.
  - 2bpp: sub_x[2:1] selects the pair, bits [7-2k:6-2k]. sub_x[0] masked.
  - 1bpp: bit = ram_din[7-sub_x].
- Colour mapping:
  - 1bpp: 1 selects fg_colour, 0 selects bg_colour.
  - 2bpp: {fg_colour[7:2], p}. 4bpp: {fg_colour[7:4], p}. 8bpp: p.
  - pixel_out[15:8] = 0 in all of these modes.
- Window off: when the delayed enable is 0, pixel_out = {8'h00, bg_colour} and window_out = 0.
- Latency: command on tick N produces pixel_out/window_out visible in the cycle after tick N+RAM_READ_CYCLES. Outputs hold between ticks.
- Simultaneous events: a tick with the enable transitioning 1→0 outputs bg and latches the new mode in the same tick; the new mode governs the next enabled pixel.
- Reset mid-line: all state clears immediately. Up to RAM_READ_CYCLES ticks of bg output follow before fresh commands emerge.

Optional Feature:
BP2R_TWO_BYTE_COLOUR_EN
- Defined: when the delayed cmd[6] = 1 and the window is enabled, pixel_out = {ram_din[15:8], ram_din[7:0]} regardless of mode and sub_x.
- Not defined: cmd[6] is dropped from the delay line and pixel_out[15:8] is always 0.

Test Plan:
- Reset: assert reset mid-stream → all outputs 0 within the same cycle; after release, the first RAM_READ_CYCLES=3 ticks output bg only.
- 1bpp, mode=8'h03, fg=8'h0F, bg=8'h01, ram_din=16'h00A5, window on, sub_x stepping 0..7 → pixel_out 000F,0001,000F,0001,0001,000F,0001,000F, each appearing 3 ticks after its command.
- 4bpp, mode=8'h01, fg=8'hC0, ram_din=16'h003E, sub_x 0 then 4 → 00C3 then 00CE; sub_x=5 behaves as 4.
- Window off: cmd_in[7]=0, bg=8'h22 → pixel_out=0022, window_out=0. A mode change to 8bpp while the window is on is ignored until the enable has been 0 on a tick.
- Alignment: RAM_READ_CYCLES=1 and 8 builds, pc_ena_in cycling 0..3 → pixel_out changes only the cycle after a tick with pc_ena_in==0; pc_ena_out equals pc_ena_in delayed 1 clk.
- BP2R_TWO_BYTE_COLOUR_EN defined, cmd_in=8'hC0, ram_din=16'h1234 → pixel_out=1234. Not defined → the same stimulus yields 0034 in 8bpp.
